// File: rtl/connection_reader.sv
// connection_reader: walks a NUM_CELLS x MAX_IN_DEGREE connection matrix
// row by row and emits one (cell, slot) edge record per set bit.
module connection_reader #(
   parameter int NUM_CELLS     = 1024,
   parameter int MAX_IN_DEGREE = 256,
   localparam int CELL_W = $clog2(NUM_CELLS),
   localparam int SLOT_W = $clog2(MAX_IN_DEGREE),
   localparam int CNT_W  = $clog2(NUM_CELLS*MAX_IN_DEGREE+1)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     abort,
   output logic                     row_rd_en,
   output logic [CELL_W-1:0]        row_addr,
   input  logic [MAX_IN_DEGREE-1:0] row_data,
   output logic                     edge_valid,
   input  logic                     edge_ready,
   output logic [CELL_W-1:0]        edge_cell,
   output logic [SLOT_W-1:0]        edge_slot,
   output logic                     busy,
   output logic                     done,
   output logic [CNT_W-1:0]         edge_count
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      SCAN,
      DONE
   } state_t;

   state_t                   state, state_nxt;
   logic [CELL_W-1:0]        row_ptr, ptr_nxt;
   logic [MAX_IN_DEGREE-1:0] mask, mask_nxt;
   logic [CNT_W-1:0]         cnt_nxt;
   logic [SLOT_W-1:0]        low_slot;
   logic                     last_row;
   logic                     hs;

   assign last_row = (row_ptr == CELL_W'(NUM_CELLS-1));

   // Lowest set bit wins: scan from the top so the last hit is the lowest.
   always_comb begin
      low_slot = '0;
      for (int i = MAX_IN_DEGREE-1; i >= 0; i--) begin
         if (mask[i]) low_slot = SLOT_W'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         row_ptr    <= '0;
         mask       <= '0;
         edge_count <= '0;
      end else begin
         state      <= state_nxt;
         row_ptr    <= ptr_nxt;
         mask       <= mask_nxt;
         edge_count <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      ptr_nxt    = row_ptr;
      mask_nxt   = mask;
      cnt_nxt    = edge_count;
      row_rd_en  = 1'b0;
      row_addr   = '0;
      edge_valid = 1'b0;
      edge_cell  = '0;
      edge_slot  = '0;
      done       = 1'b0;
      busy       = (state != IDLE);
      hs         = 1'b0;
      unique case (state)
         IDLE: begin
            if (start && !abort) begin
               state_nxt = FETCH;
               ptr_nxt   = '0;
               cnt_nxt   = '0;
            end
         end
         FETCH: begin
            row_rd_en = 1'b1;
            row_addr  = row_ptr;
            state_nxt = abort ? IDLE : LOAD;
         end
         LOAD: begin
            mask_nxt  = row_data;
            state_nxt = abort ? IDLE : SCAN;
         end
         SCAN: begin
            edge_valid = (mask != '0);
            edge_cell  = edge_valid ? row_ptr : '0;
            edge_slot  = edge_valid ? low_slot : '0;
            hs         = edge_valid && edge_ready;
            if (hs) begin
               mask_nxt = mask & (mask - MAX_IN_DEGREE'(1));
               cnt_nxt  = edge_count + CNT_W'(1);
            end
            // An abort still lets a same-cycle handshake count.
            if (abort) begin
               state_nxt = IDLE;
            end else if (mask_nxt == '0) begin
               if (last_row) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = FETCH;
                  ptr_nxt   = row_ptr + CELL_W'(1);
               end
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_connection_reader.sv
// tb_connection_reader: directed and randomized scans of a 4x8 matrix,
// checked against an edge list built from the row contents.
module tb_connection_reader;

   localparam int NC = 4;
   localparam int MD = 8;
   localparam int CW = 2;
   localparam int SW = 3;
   localparam int KW = 6;

   typedef struct packed {
      logic [CW-1:0] c;
      logic [SW-1:0] s;
   } edge_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          edge_ready = 1'b0;
   logic          row_rd_en;
   logic [CW-1:0] row_addr;
   logic [MD-1:0] row_data = '0;
   logic          edge_valid;
   logic [CW-1:0] edge_cell;
   logic [SW-1:0] edge_slot;
   logic          busy;
   logic          done;
   logic [KW-1:0] edge_count;
   logic [MD-1:0] rows [NC];

   int checks = 0;
   int errors = 0;

   connection_reader #(.NUM_CELLS(NC), .MAX_IN_DEGREE(MD)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .row_rd_en(row_rd_en), .row_addr(row_addr), .row_data(row_data),
      .edge_valid(edge_valid), .edge_ready(edge_ready),
      .edge_cell(edge_cell), .edge_slot(edge_slot),
      .busy(busy), .done(done), .edge_count(edge_count)
   );

   always #5 clk = ~clk;

   // Matrix store with one cycle of read latency.
   always @(posedge clk) begin
      if (row_rd_en) row_data <= rows[row_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_rd_en"}, row_rd_en, 0);
      check({tag, "_addr"}, row_addr, 0);
      check({tag, "_valid"}, edge_valid, 0);
      check({tag, "_cell"}, edge_cell, 0);
      check({tag, "_slot"}, edge_slot, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_count"}, edge_count, 0);
   endtask

   task automatic set_rows(input logic [MD-1:0] r0, input logic [MD-1:0] r1,
                           input logic [MD-1:0] r2, input logic [MD-1:0] r3);
      rows[0] = r0; rows[1] = r1; rows[2] = r2; rows[3] = r3;
   endtask

   task automatic rand_rows();
      for (int r = 0; r < NC; r++)
         rows[r] = ($urandom_range(0, 3) == 0) ? '0 : MD'($urandom_range(0, 255));
   endtask

   // rmode: 0 ready always, 1 ready toggling, 2 ready random.
   task automatic run_scan(input int rmode, input int abort_n,
                           input int restart_cyc);
      edge_t q[$];
      edge_t e;
      int cyc, ndone, done_cyc, acc, exp_done, frow, total, k;
      bit stalled, hs;
      logic [CW-1:0] pc;
      logic [SW-1:0] ps;
      exp_done = 1;
      for (int r = 0; r < NC; r++) begin
         k = $countones(rows[r]);
         exp_done += 2 + ((k == 0) ? 1 : k);
         for (int s = 0; s < MD; s++) begin
            if (rows[r][s]) begin
               e.c = CW'(r);
               e.s = SW'(s);
               q.push_back(e);
            end
         end
      end
      total = q.size();
      ndone = 0; done_cyc = -1; acc = 0; frow = 0;
      stalled = 0; pc = '0; ps = '0;
      @(negedge clk);
      start = 1'b1; abort = 1'b0;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      check("busy_start", busy, 1);
      while (busy && cyc < 500) begin
         start = (cyc == restart_cyc);
         abort = 1'b0;
         case (rmode)
            0: edge_ready = 1'b1;
            1: edge_ready = cyc[0];
            default: edge_ready = 1'($urandom_range(0, 1));
         endcase
         if (row_rd_en) begin
            check("rd_addr", row_addr, frow);
            frow++;
         end else begin
            check("addr_idle", row_addr, 0);
         end
         if (stalled) begin
            check("stall_valid", edge_valid, 1);
            check("stall_cell", edge_cell, pc);
            check("stall_slot", edge_slot, ps);
         end
         hs = edge_valid && edge_ready;
         if (hs) begin
            check("edge_avail", q.size() > 0, 1);
            if (q.size() > 0) begin
               e = q.pop_front();
               check("edge_cell", edge_cell, e.c);
               check("edge_slot", edge_slot, e.s);
            end
            acc++;
            if (acc == abort_n) abort = 1'b1;
         end
         if (done) begin
            ndone++;
            done_cyc = cyc;
            check("done_count", edge_count, total);
         end
         stalled = edge_valid && !edge_ready;
         pc = edge_cell;
         ps = edge_slot;
         @(negedge clk);
         cyc++;
      end
      start = 1'b0; abort = 1'b0; edge_ready = 1'b0;
      check("scan_bound", cyc < 500, 1);
      check("end_busy", busy, 0);
      check("end_valid", edge_valid, 0);
      check("end_done", done, 0);
      if (abort_n > 0) begin
         check("abort_count", edge_count, abort_n);
         check("abort_nodone", ndone, 0);
      end else begin
         check("done_pulses", ndone, 1);
         check("final_count", edge_count, total);
         check("all_edges", q.size(), 0);
         if (rmode == 0) check("done_cycle", done_cyc, exp_done);
      end
   endtask

   initial begin
      int n;
      bit seen;
      logic [KW-1:0] held;
      set_rows('0, '0, '0, '0);
      repeat (3) @(negedge clk);
      check_zero("reset");
      reset = 1'b0;

      set_rows(8'h00, 8'h00, 8'h00, 8'h00);
      run_scan(0, 0, 0);

      set_rows(8'h00, 8'h00, 8'h81, 8'h00);
      run_scan(0, 0, 0);

      set_rows(8'hFF, 8'h00, 8'h00, 8'h00);
      run_scan(1, 0, 0);

      for (int i = 0; i < 6; i++) begin
         rand_rows();
         run_scan(i % 3, 0, 0);
      end

      set_rows(8'hFF, 8'hFF, 8'hFF, 8'hFF);
      run_scan(0, 10, 0);

      rand_rows();
      rows[1] = 8'h3C;
      run_scan(0, 0, 5);

      // Reset while an edge is held valid by a stalled consumer.
      set_rows(8'hFF, 8'hFF, 8'hFF, 8'hFF);
      edge_ready = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      seen = 0;
      while (!seen && n < 20) begin
         seen = edge_valid;
         if (!seen) @(negedge clk);
         n++;
      end
      check("reset_wait_valid", seen, 1);
      reset = 1'b1;
      @(negedge clk);
      check_zero("midreset");
      reset = 1'b0;
      rand_rows();
      rows[0] = 8'h05;
      run_scan(0, 0, 0);

      // Abort alone, and start with abort, in IDLE.
      held = edge_count;
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("idle_abort_busy", busy, 0);
      check("idle_abort_count", edge_count, held);
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check("start_abort_busy", busy, 0);
      @(negedge clk);
      check("start_abort_busy2", busy, 0);
      check("start_abort_count", edge_count, held);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/connection_reader.md
CONNECTION_READER -- requirements
Module: connection_reader

Interface
REQ-001 Parameter NUM_CELLS, default 1024, sets the number of matrix rows, one per cell.
REQ-002 Parameter MAX_IN_DEGREE, default 256, sets the bits per row, one per input slot.
REQ-003 Derived constants: CELL_W = $clog2(NUM_CELLS), SLOT_W = $clog2(MAX_IN_DEGREE), CNT_W = $clog2(NUM_CELLS*MAX_IN_DEGREE+1).
REQ-004 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port start, input, 1 bit: single-cycle request to begin a full matrix scan.
REQ-007 Port abort, input, 1 bit: terminates a scan in progress.
REQ-008 Port row_rd_en, output, 1 bit: row read strobe toward the connection-matrix store.
REQ-009 Port row_addr, output, CELL_W bits: index of the row being read.
REQ-010 Port row_data, input, MAX_IN_DEGREE bits: row contents, valid exactly one cycle after row_rd_en.
REQ-011 Port edge_valid, output, 1 bit: an edge record is presented.
REQ-012 Port edge_ready, input, 1 bit: the downstream consumer accepts the edge record.
REQ-013 Port edge_cell, output, CELL_W bits: destination cell (row index) of the edge.
REQ-014 Port edge_slot, output, SLOT_W bits: input-slot index (bit position) of the edge.
REQ-015 Port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-016 Port done, output, 1 bit: one-cycle pulse on normal scan completion.
REQ-017 Port edge_count, output, CNT_W bits: number of edges accepted in the current or last scan.

Function
REQ-018 FSM states shall be IDLE, FETCH, LOAD, SCAN and DONE.
REQ-019 IDLE: start=1 -> FETCH, with row pointer=0 and edge_count=0.
REQ-020 FETCH: row_rd_en=1 and row_addr=row pointer for exactly this one cycle -> LOAD.
REQ-021 LOAD: row_data is captured into the mask register at the end of the cycle -> SCAN.
REQ-022 SCAN: edge_valid=(mask!=0); edge_slot=index of the lowest set mask bit; edge_cell=row pointer.
REQ-023 Handshake is edge_valid&&edge_ready: clear that mask bit and increment edge_count by 1.
REQ-024 With edge_valid=1 and edge_ready=0, edge_cell and edge_slot shall hold stable, and edge_valid shall not drop except on abort or reset.
REQ-025 SCAN exits when mask==0, or on a handshake that clears the last set bit: to FETCH (row pointer+1) if row pointer<NUM_CELLS-1, else to DONE.
REQ-026 An all-zero row shall cost exactly one SCAN cycle with edge_valid=0.
REQ-027 DONE: done=1 for one cycle -> IDLE; edge_count holds its value until the next accepted start.
REQ-028 Edges shall be emitted in ascending row order, then ascending slot order within a row, each set bit exactly once.
REQ-029 start in any non-IDLE state shall be ignored.
REQ-030 abort=1 in any non-IDLE state: -> IDLE next cycle; edge_valid=0 from that cycle; no done pulse; edge_count frozen.
REQ-031 Simultaneous abort and handshake in SCAN: the handshake counts (edge_count+1), then -> IDLE.
REQ-032 abort in IDLE shall have no effect; start and abort together in IDLE shall leave the FSM in IDLE.
REQ-033 Row pointer shall never exceed NUM_CELLS-1; row_addr shall be 0 whenever row_rd_en=0.
REQ-034 edge_count cannot overflow: its maximum is NUM_CELLS*MAX_IN_DEGREE, which fits CNT_W.

Reset
REQ-035 reset=1 at a clock edge shall force: state=IDLE, row pointer=0, mask=0, edge_count=0, and all outputs 0.
REQ-036 reset shall take priority over start, abort and any handshake, including mid-scan; no done pulse is issued.

Verification
Bench parameters: NUM_CELLS=4, MAX_IN_DEGREE=8, and a 1-cycle-latency row model.
REQ-037 All rows 0x00, start -> no edge_valid; done 13 cycles after start is sampled (4 rows × 3 cycles, plus DONE); edge_count=0.
REQ-038 Row2=0x81, others 0, edge_ready=1 -> edges (2,0) then (2,7); edge_count=2; done pulses once.
REQ-039 Row0=0xFF, edge_ready toggling 1/0 -> eight edges, slots 0..7 in order, each stable while stalled; edge_count=8.
REQ-040 All rows 0xFF, abort asserted with the 10th edge valid and ready -> that edge counts, edge_count=10, IDLE next cycle, no done.
REQ-041 reset mid-SCAN with edge_valid=1 -> next cycle all outputs 0; a following start rescans from row 0.
REQ-042 start pulsed again during a busy scan -> ignored; the full scan completes with exactly one done pulse.
